// File: rtl/nibble_pkg.sv
// Shared constants and types for the time-shared nibble adder sequencer.
package nibble_pkg;

  localparam int unsigned LANES      = 4;
  localparam int unsigned LANE_W     = 4;
  localparam int unsigned WORD_W     = LANES * LANE_W;
  localparam int unsigned LANE_IDX_W = $clog2(LANES);

  localparam logic OP_PADDSB = 1'b0;
  localparam logic OP_ADD16  = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  localparam logic [LANE_W-1:0] NIB_POS_SAT  = 4'h7;
  localparam logic [LANE_W-1:0] NIB_NEG_SAT  = 4'h8;
  localparam logic [WORD_W-1:0] WORD_POS_SAT = 16'h7FFF;
  localparam logic [WORD_W-1:0] WORD_NEG_SAT = 16'h8000;

  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

endpackage

// File: rtl/nibble_add_sat.sv
// Combinational 4-bit signed adder with carry in/out, signed overflow and
// optional per-nibble saturation.
module nibble_add_sat
  import nibble_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              cin,
  input  logic              sat,
  output logic [LANE_W-1:0] sum,
  output logic              cout,
  output logic              ovfl
);

  logic [LANE_W:0]   raw;
  logic [LANE_W-1:0] low;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {{LANE_W{1'b0}}, cin};
    // Sum of the bits below the MSB; its top bit is the carry into the MSB.
    low  = {1'b0, a[LANE_W-2:0]} + {1'b0, b[LANE_W-2:0]} + {{(LANE_W-1){1'b0}}, cin};
    cout = raw[LANE_W];
    ovfl = low[LANE_W-1] ^ raw[LANE_W];
    sum  = raw[LANE_W-1:0];
    if (sat && ovfl) begin
      sum = a[LANE_W-1] ? NIB_NEG_SAT : NIB_POS_SAT;
    end
  end

endmodule

// File: rtl/nibble_add_sched.sv
// Sequencer sharing one nibble adder across four lanes (PADDSB or ADD16).
// Saturation is enabled by defining NIBBLE_SAT_EN; otherwise results wrap.
module nibble_add_sched
  import nibble_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              ready,
  output logic              done,
  output logic [WORD_W-1:0] sum,
  output logic [LANES-1:0]  lane_ovfl,
  output logic              ovfl
);

  state_e                  state_q;
  logic                    op_q;
  logic [WORD_W-1:0]       a_q;
  logic [WORD_W-1:0]       b_q;
  logic [LANE_IDX_W-1:0]   lane_q;
  logic                    carry_q;
  logic [WORD_W-1:0]       work_q;
  logic [LANES-1:0]        flags_q;

  logic [LANE_W-1:0] nib_a;
  logic [LANE_W-1:0] nib_b;
  logic [LANE_W-1:0] nib_sum;
  logic              nib_cin;
  logic              nib_sat;
  logic              nib_cout;
  logic              nib_ovfl;
  logic              lane_flag;
  logic [WORD_W-1:0] word_res;

  always_comb begin
    nib_a   = a_q[lane_q * LANE_W +: LANE_W];
    nib_b   = b_q[lane_q * LANE_W +: LANE_W];
    nib_cin = (op_q == OP_ADD16) ? carry_q : 1'b0;
`ifdef NIBBLE_SAT_EN
    nib_sat = (op_q == OP_PADDSB);
`else
    nib_sat = 1'b0;
`endif
    // In ADD16 only the top lane carries a meaningful signed overflow.
    lane_flag = (op_q == OP_ADD16 && lane_q != LAST_LANE) ? 1'b0 : nib_ovfl;
  end

  always_comb begin
    word_res = work_q;
`ifdef NIBBLE_SAT_EN
    if (op_q == OP_ADD16 && flags_q[LANES-1]) begin
      word_res = a_q[WORD_W-1] ? WORD_NEG_SAT : WORD_POS_SAT;
    end
`endif
  end

  nibble_add_sat u_add (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (nib_cin),
    .sat  (nib_sat),
    .sum  (nib_sum),
    .cout (nib_cout),
    .ovfl (nib_ovfl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= OP_PADDSB;
      a_q       <= '0;
      b_q       <= '0;
      lane_q    <= '0;
      carry_q   <= 1'b0;
      work_q    <= '0;
      flags_q   <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
      sum       <= '0;
      lane_ovfl <= '0;
      ovfl      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            lane_q  <= '0;
            carry_q <= 1'b0;
            ready   <= 1'b0;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          work_q[lane_q * LANE_W +: LANE_W] <= nib_sum;
          flags_q[lane_q]                   <= lane_flag;
          carry_q                           <= nib_cout;
          lane_q                            <= lane_q + 1'b1;
          if (lane_q == LAST_LANE) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          sum       <= word_res;
          lane_ovfl <= flags_q;
          ovfl      <= |flags_q;
          done      <= 1'b1;
          ready     <= 1'b1;
          state_q   <= StIdle;
        end
        default: begin
          ready   <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_sched.sv
// Directed self-checking bench for nibble_add_sched; honours NIBBLE_SAT_EN.
module tb_nibble_add_sched;

`ifdef NIBBLE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        done;
  logic [15:0] sum;
  logic [3:0]  lane_ovfl;
  logic        ovfl;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] sa [24];
  logic [15:0] sb [24];
  logic        so [24];

  always #5 clk = ~clk;

  nibble_add_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done      (done),
    .sum       (sum),
    .lane_ovfl (lane_ovfl),
    .ovfl      (ovfl)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference arithmetic on signed integers, independent of carry logic.
  function automatic void model(input logic o, input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] s, output logic [3:0] f);
    int t;
    s = '0;
    f = '0;
    if (o == 1'b0) begin
      for (int i = 0; i < 4; i++) begin
        t = int'($signed(x[i*4 +: 4])) + int'($signed(y[i*4 +: 4]));
        f[i] = (t > 7) || (t < -8);
        s[i*4 +: 4] = 4'(t);
        if (SAT && t > 7)  s[i*4 +: 4] = 4'h7;
        if (SAT && t < -8) s[i*4 +: 4] = 4'h8;
      end
    end else begin
      t = int'($signed(x)) + int'($signed(y));
      f[3] = (t > 32767) || (t < -32768);
      s = 16'(t);
      if (SAT && t > 32767)  s = 16'h7FFF;
      if (SAT && t < -32768) s = 16'h8000;
    end
  endfunction

  task automatic run_op(input string tag, input logic o, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] exp_sum,
                        input logic [3:0] exp_f);
    int cnt;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 16'hDEAD;
    b     = 16'hBEEF;
    check({tag, "_ready_low"}, {15'b0, ready}, 16'h0000);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 10) begin
      @(posedge clk);
      #1;
      cnt++;
      if (done) seen = 1'b1;
    end
    check({tag, "_latency"}, 16'(cnt), 16'd5);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_lane_ovfl"}, {12'b0, lane_ovfl}, {12'b0, exp_f});
    check({tag, "_ovfl"}, {15'b0, ovfl}, {15'b0, |exp_f});
    check({tag, "_ready_back"}, {15'b0, ready}, 16'h0001);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {15'b0, done}, 16'h0000);
  endtask

  initial begin
    logic [15:0] es;
    logic [3:0]  ef;
    int          dcnt;

    rst   = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("rst_ready", {15'b0, ready}, 16'h0001);
    check("rst_done", {15'b0, done}, 16'h0000);
    check("rst_sum", sum, 16'h0000);
    check("rst_lane_ovfl", {12'b0, lane_ovfl}, 16'h0000);
    check("rst_ovfl", {15'b0, ovfl}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    run_op("padd_plain", 1'b0, 16'h1234, 16'h1111, 16'h2345, 4'h0);
    run_op("padd_posovf", 1'b0, 16'h7878, 16'h1818, SAT ? 16'h7878 : 16'h8080, 4'hF);
    run_op("padd_negovf", 1'b0, 16'h8888, 16'h8888, SAT ? 16'h8888 : 16'h0000, 4'hF);
    run_op("add16_chain", 1'b1, 16'h00FF, 16'h0001, 16'h0100, 4'h0);
    run_op("add16_posovf", 1'b1, 16'h7FFF, 16'h0001, SAT ? 16'h7FFF : 16'h8000, 4'h8);
    run_op("add16_negovf", 1'b1, 16'h8000, 16'hFFFF, SAT ? 16'h8000 : 16'h7FFF, 4'h8);

    // Back-to-back: start held, operands change every cycle.
    for (int k = 0; k < 24; k++) begin
      sa[k] = 16'(k * 4951 + 9320);
      sb[k] = 16'(k * 3855) ^ 16'h8421;
      so[k] = ((k / 6) % 2) == 1;
    end
    @(negedge clk);
    start = 1'b1;
    op    = so[0];
    a     = sa[0];
    b     = sb[0];
    for (int k = 0; k < 24; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("stream_done_%0d", k), {15'b0, done}, {15'b0, (k % 6) == 5});
      check($sformatf("stream_ready_%0d", k), {15'b0, ready}, {15'b0, (k % 6) == 5});
      if ((k % 6) == 5) begin
        model(so[k-5], sa[k-5], sb[k-5], es, ef);
        check($sformatf("stream_sum_%0d", k), sum, es);
        check($sformatf("stream_lane_ovfl_%0d", k), {12'b0, lane_ovfl}, {12'b0, ef});
      end
      @(negedge clk);
      if (k < 23) begin
        op = so[k+1];
        a  = sa[k+1];
        b  = sb[k+1];
      end
    end
    start = 1'b0;

    // Reset while lane 2 is being computed.
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 16'h1234;
    b     = 16'h1111;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ready", {15'b0, ready}, 16'h0001);
    check("midrst_done", {15'b0, done}, 16'h0000);
    check("midrst_sum", sum, 16'h0000);
    check("midrst_lane_ovfl", {12'b0, lane_ovfl}, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    dcnt = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    check("midrst_no_done", 16'(dcnt), 16'd0);
    check("midrst_sum_held", sum, 16'h0000);
    run_op("after_rst", 1'b1, 16'h1234, 16'h1111, 16'h2345, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
